// File: rtl/noc_pkg.sv
// Shared NoC definitions: default router dimensions, flit type, arbiter state
// encoding and a small index helper used by the port arbiters.
package noc_pkg;

  localparam int NUM_IN_DEF  = 4;
  localparam int FLIT_W_DEF  = 32;
  localparam int CREDITS_DEF = 4;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first asserted request at or above
// ptr (wrapping at N) wins. Shared by all output-port arbiters of the router.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [PW-1:0] gnt_idx,
  output logic          found
);

  int idx;

  // Scan requests starting at ptr; the first hit is the winner.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise the
    // "no request" path leaves them unassigned and a latch is inferred.
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[PW'(idx)]) begin
        found               = 1'b1;
        gnt_oh[PW'(idx)]    = 1'b1;
        gnt_idx             = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin arbiter for one router output port. A winner is chosen
// in IDLE, then owns the link from head flit to tail flit. Flits leave through
// a one-cycle output register, gated by a credit counter that mirrors the free
// slots of the downstream buffer.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN  = NUM_IN_DEF,
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  input  logic [NUM_IN-1:0]        in_tail,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_tail,
  input  logic                     credit_return,
  output logic [NUM_IN-1:0]        grant_oh,
  output logic                     busy,
  output logic                     credit_err
);

  localparam int PTR_W  = $clog2(NUM_IN);
  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [CRED_W-1:0]  credits;

  logic [NUM_IN-1:0]  pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;

  logic               xfer;
  logic [FLIT_W-1:0]  sel_flit;
  logic               sel_tail;

  rr_pick #(
    .N  (NUM_IN),
    .PW (PTR_W)
  ) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .found   (pick_found)
  );

  // Owner's flit/tail mux and the accept handshake (owner valid and a credit left).
  always_comb begin
    sel_flit = '0;
    sel_tail = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_flit = in_flit[i*FLIT_W +: FLIT_W];
        sel_tail = in_tail[i];
      end
    end
    in_ready = '0;
    xfer     = 1'b0;
    if (state == LOCKED && credits != '0 && in_valid[grant_idx]) begin
      in_ready = grant_oh;
      xfer     = 1'b1;
    end
  end

  assign busy = (state == LOCKED);

  // Arbitration FSM, credit counter and the output link register.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses <= so every register samples the pre-edge
    // values; a blocking = would let later lines see already-updated state.
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      grant_oh   <= '0;
      credits    <= CRED_MAX;
      out_valid  <= 1'b0;
      out_flit   <= '0;
      out_tail   <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_flit <= sel_flit;
        out_tail <= sel_tail;
      end

      // A send and a returned slot in the same cycle cancel out.
      if (xfer && !credit_return) begin
        credits <= credits - CRED_ONE;
      end else if (credit_return && !xfer) begin
        if (credits == CRED_MAX) begin
          credit_err <= 1'b1;
        end else begin
          credits <= credits + CRED_ONE;
        end
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= LOCKED;
            grant_oh  <= pick_oh;
            grant_idx <= pick_idx;
          end
        end
        LOCKED: begin
          // Grant is released only by the tail; a stalled owner keeps the link.
          if (xfer && sel_tail) begin
            state    <= IDLE;
            grant_oh <= '0;
            rr_ptr   <= PTR_W'(wrap_inc(int'(grant_idx), NUM_IN));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
